seq_detect_fsm: RTL and testbench

Parametrised serial bit-pattern detector. It is the successor to the fixed 3-state/4-state "101" Moore detector. It generalises pattern width, makes the pattern runtime-loadable, adds a per-bit valid qualifier, selects overlapping or non-overlapping matching, and keeps a saturating match counter. It sits on any single-bit serial stream, for example a framing/sync-word hunt, and with default parameters it behaves exactly like the legacy overlapping "101" detector.

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/seq_detect_fsm.sv | 99 +++++++++
 tb/tb_seq_detect_fsm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_detect_pkg;

  // Detector states: nothing seen, partial window, full window matching / not matching.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    MATCH   = 2'd2,
    NOMATCH = 2'd3
  } state_t;

  // Width needed to count valid history bits from 0 up to and including pat_w.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Next count for one increment, pinned at all-ones once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Counter register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Parametrised serial bit-pattern detector with loadable pattern, per-bit
// valid qualifier, overlapping / non-overlapping matching and a saturating
// match counter. Default parameters give the legacy overlapping "101" detector.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W     = 3,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(3'b101)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W    = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  state_t            state;

  logic              accept;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;

  // The oldest history bit falls off the window on every shift.
  logic              unused_hist_msb;
  assign unused_hist_msb = hist[PAT_W-1];

  // Window after the incoming bit and whether it completes a match; a pattern
  // load on the same edge discards the bit.
  always_comb begin
    accept   = in_valid & ~pat_load;
    hist_nxt = {hist[PAT_W-2:0], in};
    fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    hit      = accept && (fill_nxt == FILL_FULL) && (hist_nxt == pat_q);
  end

  // Pattern register, history window, fill count, state and registered match flag.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pat_q <= RESET_PAT;
      hist  <= '0;
      fill  <= '0;
      state <= EMPTY;
      out   <= 1'b0;
    end else if (pat_load) begin
      pat_q <= pat;
      hist  <= '0;
      fill  <= '0;
      state <= EMPTY;
      out   <= 1'b0;
    end else if (accept) begin
      hist <= hist_nxt;
      case (state)
        // First bit of a fresh window can never complete a pattern of width >= 2.
        EMPTY: begin
          fill  <= fill_nxt;
          state <= FILLING;
          out   <= 1'b0;
        end
        // Partial and full windows share one evaluation; non-overlap restarts the window.
        default: begin
          if (hit) begin
            fill  <= overlap ? FILL_FULL : '0;
            state <= MATCH;
            out   <= 1'b1;
          end else begin
            fill  <= fill_nxt;
            state <= (fill_nxt == FILL_FULL) ? NOMATCH : FILLING;
            out   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Match counter advances on the same edge the flag rises.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .inc      (hit),
    .clr      (cnt_clr),
    .cnt      (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: vector table, hand-written corner sequences and
// randomized traffic against a bit-queue reference model.
module tb_seq_detect_fsm;

  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          in_valid;
  logic          in_bit;
  logic          overlap;
  logic          pat_load;
  logic [PW-1:0] pat;
  logic          cnt_clr;
  logic          out_a;
  logic          out_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_fsm dut_a (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in(in_bit),
    .overlap(overlap), .pat_load(pat_load), .pat(pat), .cnt_clr(cnt_clr),
    .out(out_a), .match_cnt(cnt_a)
  );

  seq_detect_fsm #(.CNT_W(2)) dut_b (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in(in_bit),
    .overlap(overlap), .pat_load(pat_load), .pat(pat), .cnt_clr(cnt_clr),
    .out(out_b), .match_cnt(cnt_b)
  );

  // Reference model: queue of accepted bits since the last restart.
  bit            mq[$];
  logic [PW-1:0] m_pat;
  logic          m_out;
  int            m_cnt_a;
  int            m_cnt_b;

  function automatic void model_reset();
    mq.delete();
    m_pat   = 3'b101;
    m_out   = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endfunction

  function automatic void model_step(input logic v, input logic b, input logic ov,
                                     input logic pl, input logic [PW-1:0] p, input logic clr);
    bit            hit;
    logic [PW-1:0] w;
    hit = 1'b0;
    if (pl) begin
      m_pat = p;
      mq.delete();
      m_out = 1'b0;
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > PW) void'(mq.pop_front());
      if (mq.size() == PW) begin
        for (int k = 0; k < PW; k++) w[PW-1-k] = mq[k];
        hit = (w == m_pat);
      end
      m_out = hit;
      if (hit && !ov) mq.delete();
    end
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare just after.
  task automatic cyc(input logic v, input logic b, input logic ov, input logic pl,
                     input logic [PW-1:0] p, input logic clr);
    in_valid = v;
    in_bit   = b;
    overlap  = ov;
    pat_load = pl;
    pat      = p;
    cnt_clr  = clr;
    @(posedge clk);
    model_step(v, b, ov, pl, p, clr);
    #1;
    chk("model_out_a", out_a, m_out);
    chk("model_out_b", out_b, m_out);
    chk("model_cnt_a", cnt_a, m_cnt_a);
    chk("model_cnt_b", cnt_b, m_cnt_b);
  endtask

  task automatic expect_a(input string name, input logic eo, input int ec);
    chk({name, "_out"}, out_a, eo);
    chk({name, "_cnt"}, cnt_a, ec);
  endtask

  typedef struct {
    logic          v;
    logic          b;
    logic          ov;
    logic          pl;
    logic [PW-1:0] p;
    logic          clr;
    logic          eo;
    int            ec;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // overlapping 1,0,1,0,1
    tbl[0]  = '{1, 1, 1, 0, 3'b101, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 3'b101, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 3'b101, 0, 1, 1};
    tbl[3]  = '{1, 0, 1, 0, 3'b101, 0, 0, 1};
    tbl[4]  = '{1, 1, 1, 0, 3'b101, 0, 1, 2};
    // reload pattern and clear count; the valid bit is discarded
    tbl[5]  = '{1, 1, 0, 1, 3'b101, 1, 0, 0};
    // non-overlapping 1,0,1,0,1
    tbl[6]  = '{1, 1, 0, 0, 3'b101, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 3'b101, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 3'b101, 0, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 3'b101, 0, 0, 1};
    tbl[10] = '{1, 1, 0, 0, 3'b101, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 3'b101, 0, 0, 1};

    areset_n = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat      = 3'b000;
    cnt_clr  = 1'b0;
    model_reset();
    #12;
    expect_a("reset", 1'b0, 0);
    chk("reset_cnt_b", cnt_b, 0);
    areset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].ov, tbl[i].pl, tbl[i].p, tbl[i].clr);
      expect_a($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].ec);
    end

    // Bits separated by idle gaps; flag holds through a later gap
    cyc(0, 0, 1, 1, 3'b101, 1);
    expect_a("gap_clear", 1'b0, 0);
    cyc(1, 1, 1, 0, 3'b101, 0);
    cyc(0, 0, 1, 0, 3'b101, 0);
    cyc(0, 0, 1, 0, 3'b101, 0);
    cyc(1, 0, 1, 0, 3'b101, 0);
    expect_a("gap_b2", 1'b0, 0);
    cyc(0, 1, 1, 0, 3'b101, 0);
    cyc(0, 1, 1, 0, 3'b101, 0);
    cyc(1, 1, 1, 0, 3'b101, 0);
    expect_a("gap_b3", 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 3'b101, 0);
      expect_a("gap_hold", 1'b1, 1);
    end

    // Pattern load beats a valid bit; then overlapping 111 matches
    cyc(0, 0, 1, 1, 3'b101, 1);
    cyc(1, 1, 1, 0, 3'b101, 0);
    cyc(1, 1, 1, 0, 3'b101, 0);
    cyc(1, 1, 1, 1, 3'b111, 0);
    expect_a("load_discard", 1'b0, 0);
    cyc(1, 1, 1, 0, 3'b111, 0);
    expect_a("p111_b1", 1'b0, 0);
    cyc(1, 1, 1, 0, 3'b111, 0);
    expect_a("p111_b2", 1'b0, 0);
    cyc(1, 1, 1, 0, 3'b111, 0);
    expect_a("p111_b3", 1'b1, 1);
    cyc(1, 1, 1, 0, 3'b111, 0);
    expect_a("p111_b4", 1'b1, 2);

    // Saturation of the 2-bit counter, then clear colliding with a match
    cyc(0, 0, 1, 1, 3'b101, 1);
    for (int i = 0; i < 11; i++) cyc(1, (i % 2 == 0), 1, 0, 3'b101, 0);
    expect_a("sat_a", 1'b1, 5);
    chk("sat_b", cnt_b, 3);
    cyc(1, 0, 1, 0, 3'b101, 0);
    cyc(1, 1, 1, 0, 3'b101, 1);
    expect_a("clr_vs_match", 1'b1, 0);
    chk("clr_vs_match_b", cnt_b, 0);

    // Custom pattern, then async reset between edges restores 101
    cyc(0, 0, 1, 1, 3'b110, 1);
    cyc(1, 1, 1, 0, 3'b110, 0);
    cyc(1, 1, 1, 0, 3'b110, 0);
    cyc(1, 0, 1, 0, 3'b110, 0);
    expect_a("p110_hit", 1'b1, 1);
    #2;
    areset_n = 1'b0;
    #1;
    expect_a("areset_now", 1'b0, 0);
    chk("areset_now_b", cnt_b, 0);
    model_reset();
    #1;
    areset_n = 1'b1;
    cyc(1, 1, 1, 0, 3'b000, 0);
    cyc(1, 0, 1, 0, 3'b000, 0);
    cyc(1, 1, 1, 0, 3'b000, 0);
    expect_a("default_pat", 1'b1, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 39) == 0, PW'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
